wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have no parameters; buffer depth is fixed at 2 and data width at 32.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named as follows:
  clock  in  1  rising-edge clock
  ctrl_reset  in  1  asynchronous, active-high reset
REQ-003 The block SHALL have these request ports:
  alu_valid  in  1  ALU writeback request; cannot be back-pressured
  alu_rd  in  5  ALU destination register
  alu_data  in  32  ALU result
  md_valid  in  1  multdiv result request; held until accepted
  md_rd  in  5  multdiv destination register
  md_data  in  32  multdiv result
  md_ready  out  1  multdiv result accepted when md_valid & md_ready
  md_start  in  1  multdiv op issued this cycle
  md_start_rd  in  5  destination register of the issued op
REQ-004 The block SHALL have these decode-check ports:
  chk_rs1  in  5  decode source A
  chk_rs2  in  5  decode source B
  chk_rd  in  5  decode destination
  stall  out  1  decode must hold
REQ-005 The block SHALL drive the regfile write port through these registered outputs:
  ctrl_writeEnable  out  1  regfile write enable
  ctrl_writeReg  out  5  regfile write index
  data_writeReg  out  32  regfile write data
REQ-006 The block SHALL also drive md_count  out  2  (buffered multdiv entries, 0..2).

Function
REQ-007 Each write grant SHALL be registered: a request selected in cycle N SHALL appear on ctrl_writeEnable, ctrl_writeReg and data_writeReg in cycle N+1, for exactly one cycle.
REQ-008 Priority SHALL be: alu_valid first; buffer head second; a direct md bypass third (only when the buffer is empty).
REQ-009 When no source is selected in a cycle, ctrl_writeEnable SHALL be 0 in the next cycle; ctrl_writeReg and data_writeReg SHALL hold their previous values.
REQ-010 A selected request with destination 0 SHALL consume its slot but SHALL drive ctrl_writeEnable 0.
REQ-011 md_ready SHALL be the combinational function (md_count < 2).
REQ-012 An accepted md result SHALL be enqueued unless it is bypassed straight to the write port in the same cycle.
REQ-013 When the head is written and a new md result is accepted in the same cycle, md_count SHALL be unchanged.
REQ-014 The buffer SHALL be FIFO; md results SHALL be written in acceptance order.
REQ-015 The scoreboard SHALL hold 32 busy bits; md_start with md_start_rd != 0 SHALL set busy[md_start_rd] at the clock edge.
REQ-016 A busy bit SHALL clear at the edge that ends the cycle in which ctrl_writeEnable presents the md write to that register.
REQ-017 When a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-018 busy[0] SHALL always read 0.
REQ-019 stall SHALL be combinational: busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd] | (md_count == 2).
REQ-020 ALU writes SHALL never be dropped or delayed by more than one cycle, including when the buffer is full.
REQ-021 md results arriving while the buffer is full SHALL be held upstream through md_ready = 0, never lost.

Reset
REQ-022 Asserting ctrl_reset SHALL immediately, without waiting for a clock edge, force all of the following:
  - ctrl_writeEnable 0, ctrl_writeReg 0, data_writeReg 0
  - md_count 0 with both buffer entries invalid
  - all busy bits 0, stall 0, md_ready 1
REQ-023 A reset asserted mid-operation SHALL discard any buffered results without writing them.
REQ-024 The first grant after reset deassertion SHALL occur no earlier than the first rising edge at which ctrl_reset is low.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - ALU only: alu_valid=1, alu_rd=5, alu_data=0x12345678 in cycle N -> cycle N+1 shows we=1, reg=5, data=0x12345678.
  - Bypass: buffer empty, alu_valid=0, md_valid=1, md_rd=7, md_data=0xDEADBEEF -> cycle N+1 write to r7; md_count stays 0.
  - Conflict: alu_valid and md_valid (rd 3 / rd 9) together -> r3 written at N+1, md_count=1, r9 written at N+2 once alu_valid drops.
  - Full buffer: three md results arrive back-to-back under continuous alu_valid -> md_ready=0 on the third, stall=1 while md_count=2; no loss after the ALU stops.
  - Scoreboard: md_start with md_start_rd=4, then chk_rs1=4 -> stall=1 until the edge after the r4 md write; chk_rd=0 never stalls.
  - Reset: reset asserted with md_count=2 and busy[4]=1 -> all outputs return to reset values asynchronously; no pending write appears afterward.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: ALU writes take priority, multdiv results are
// buffered in a 2-entry FIFO, and a busy scoreboard stalls decode on pending md writes.
module wb_port_arbiter (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        md_start,
  input  logic [4:0]  md_start_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        stall,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [1:0]  md_count
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_HEAD,
    SRC_BYPASS
  } src_e;

  logic [4:0]  buf_rd   [2];
  logic [31:0] buf_data [2];
  logic        head;
  logic        tail;
  logic [31:0] busy;
  logic        we_is_md;

  src_e        src;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        md_accept;
  logic        enq;
  logic        pop;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign md_ready  = (md_count != 2'd2);
  assign md_accept = md_valid & md_ready;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    src      = SRC_NONE;
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (alu_valid) begin
      src = SRC_ALU;
    end else if (md_count != 2'd0) begin
      src      = SRC_HEAD;
      sel_rd   = buf_rd[head];
      sel_data = buf_data[head];
    end else if (md_accept) begin
      src      = SRC_BYPASS;
      sel_rd   = md_rd;
      sel_data = md_data;
    end
  end

  assign pop  = (src == SRC_HEAD);
  assign enq  = md_accept & (src != SRC_BYPASS);
  // Enqueue only happens with 0 or 1 entries, so the free slot sits count[0] past the head.
  assign tail = head ^ md_count[0];

  assign set_mask = (md_start && md_start_rd != 5'd0) ? (32'd1 << md_start_rd) : 32'd0;
  assign clr_mask = (ctrl_writeEnable && we_is_md) ? (32'd1 << ctrl_writeReg) : 32'd0;

  assign stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd] | (md_count == 2'd2);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
      we_is_md         <= 1'b0;
      md_count         <= 2'd0;
      head             <= 1'b0;
      busy             <= 32'd0;
    end else begin
      if (src != SRC_NONE) begin
        ctrl_writeEnable <= (sel_rd != 5'd0);
        ctrl_writeReg    <= sel_rd;
        data_writeReg    <= sel_data;
        we_is_md         <= (src != SRC_ALU);
      end else begin
        ctrl_writeEnable <= 1'b0;
        we_is_md         <= 1'b0;
      end
      md_count <= md_count + {1'b0, enq} - {1'b0, pop};
      head     <= head ^ pop;
      // Set is applied after clear so a same-cycle set wins; bit 0 is never set.
      busy     <= (busy & ~clr_mask) | set_mask;
    end
  end

  // NOTE: buffer payload is not reset; md_count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (enq) begin
      buf_rd[tail]   <= md_rd;
      buf_data[tail] <= md_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a queue-based reference model compared every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_start;
  logic [4:0]  md_start_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [1:0]  md_count;

  int n_cmp = 0;
  int n_bad = 0;

  wb_port_arbiter dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .md_start         (md_start),
    .md_start_rd      (md_start_rd),
    .chk_rs1          (chk_rs1),
    .chk_rs2          (chk_rs2),
    .chk_rd           (chk_rd),
    .stall            (stall),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .md_count         (md_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending md results as a queue, busy bits as an array.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         m_q[$];
  bit  [31:0]  m_busy  = '0;
  bit          m_we    = 1'b0;
  bit          m_we_md = 1'b0;
  logic [4:0]  m_reg   = 5'd0;
  logic [31:0] m_data  = 32'd0;

  always @(posedge clock or posedge ctrl_reset) begin : model
    bit  acc;
    bit  have;
    bit  g_md;
    wr_t g;
    if (ctrl_reset) begin
      m_q.delete();
      m_busy  = '0;
      m_we    = 1'b0;
      m_we_md = 1'b0;
      m_reg   = 5'd0;
      m_data  = 32'd0;
    end else begin
      acc = md_valid && (m_q.size() < 2);
      if (m_we && m_we_md) m_busy[m_reg] = 1'b0;
      if (md_start && md_start_rd != 5'd0) m_busy[md_start_rd] = 1'b1;
      have = 1'b1;
      g_md = 1'b1;
      g    = '0;
      if (alu_valid) begin
        g    = '{rd: alu_rd, data: alu_data};
        g_md = 1'b0;
      end else if (m_q.size() > 0) begin
        g = m_q.pop_front();
      end else if (acc) begin
        g   = '{rd: md_rd, data: md_data};
        acc = 1'b0;
      end else begin
        have = 1'b0;
      end
      if (acc) m_q.push_back('{rd: md_rd, data: md_data});
      if (have) begin
        m_we    = (g.rd != 5'd0);
        m_reg   = g.rd;
        m_data  = g.data;
        m_we_md = g_md;
      end else begin
        m_we    = 1'b0;
        m_we_md = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    bit exp_stall;
    exp_stall = m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd] | (m_q.size() == 2);
    check("cyc_we",    {31'd0, ctrl_writeEnable}, {31'd0, m_we});
    check("cyc_reg",   {27'd0, ctrl_writeReg},    {27'd0, m_reg});
    check("cyc_data",  data_writeReg,             m_data);
    check("cyc_count", {30'd0, md_count},         m_q.size());
    check("cyc_ready", {31'd0, md_ready},         {31'd0, m_q.size() < 2});
    check("cyc_stall", {31'd0, stall},            {31'd0, exp_stall});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    md_valid    = 1'b0; md_rd  = 5'd0; md_data  = 32'd0;
    md_start    = 1'b0; md_start_rd = 5'd0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic set_md(input logic [4:0] rd, input logic [31:0] d);
    md_valid = 1'b1; md_rd = rd; md_data = d;
  endtask

  task automatic check_wr(input string name, input logic we, input logic [4:0] rd,
                          input logic [31:0] d);
    check({name, "_we"},   {31'd0, ctrl_writeEnable}, {31'd0, we});
    check({name, "_reg"},  {27'd0, ctrl_writeReg},    {27'd0, rd});
    check({name, "_data"}, data_writeReg,             d);
  endtask

  initial begin
    ctrl_reset = 1'b1;
    idle();
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    repeat (2) tick();
    check_wr("rst", 1'b0, 5'd0, 32'd0);
    check("rst_count", {30'd0, md_count}, 32'd0);
    check("rst_ready", {31'd0, md_ready}, 32'd1);
    check("rst_stall", {31'd0, stall},    32'd0);
    ctrl_reset = 1'b0;
    tick();

    // ALU only, then an idle cycle that must hold reg/data.
    set_alu(5'd5, 32'h1234_5678);
    tick(); idle();
    check_wr("alu", 1'b1, 5'd5, 32'h1234_5678);
    tick();
    check_wr("alu_idle", 1'b0, 5'd5, 32'h1234_5678);

    // Bypass with an empty buffer.
    set_md(5'd7, 32'hDEAD_BEEF);
    #1 check("byp_ready", {31'd0, md_ready}, 32'd1);
    tick(); idle();
    check_wr("byp", 1'b1, 5'd7, 32'hDEAD_BEEF);
    check("byp_count", {30'd0, md_count}, 32'd0);

    // Destination 0 consumes the slot without enabling the write.
    set_alu(5'd0, 32'hAAAA_0000);
    tick(); idle();
    check_wr("rd0", 1'b0, 5'd0, 32'hAAAA_0000);

    // Conflict: ALU wins, md result is buffered then written.
    set_alu(5'd3, 32'h0000_0033);
    set_md(5'd9, 32'h0000_0099);
    tick(); idle();
    check_wr("conf_alu", 1'b1, 5'd3, 32'h0000_0033);
    check("conf_count1", {30'd0, md_count}, 32'd1);
    tick();
    check_wr("conf_md", 1'b1, 5'd9, 32'h0000_0099);
    check("conf_count0", {30'd0, md_count}, 32'd0);

    // Full buffer under continuous ALU traffic.
    set_alu(5'd10, 32'h100); set_md(5'd20, 32'h200);
    tick();
    check_wr("full_a10", 1'b1, 5'd10, 32'h100);
    set_alu(5'd11, 32'h101); set_md(5'd21, 32'h201);
    tick();
    check("full_count2", {30'd0, md_count}, 32'd2);
    set_alu(5'd12, 32'h102); set_md(5'd22, 32'h202);
    #1 check("full_ready0", {31'd0, md_ready}, 32'd0);
    check("full_stall", {31'd0, stall}, 32'd1);
    tick();
    set_alu(5'd13, 32'h103);
    tick();
    check_wr("full_a13", 1'b1, 5'd13, 32'h103);
    alu_valid = 1'b0;
    tick();
    check_wr("full_m20", 1'b1, 5'd20, 32'h200);
    check("full_count_pop", {30'd0, md_count}, 32'd1);
    #1 check("full_ready1", {31'd0, md_ready}, 32'd1);
    tick(); idle();
    check_wr("full_m21", 1'b1, 5'd21, 32'h201);
    check("full_count_same", {30'd0, md_count}, 32'd1);
    tick();
    check_wr("full_m22", 1'b1, 5'd22, 32'h202);
    check("full_count_end", {30'd0, md_count}, 32'd0);

    // Scoreboard: set, hold, rd0 never stalls, clear after the write, set wins.
    md_start = 1'b1; md_start_rd = 5'd4;
    tick(); idle();
    chk_rs1 = 5'd4;
    #1 check("sb_stall_set", {31'd0, stall}, 32'd1);
    md_start = 1'b1; md_start_rd = 5'd0;
    tick(); idle();
    check("sb_stall_hold", {31'd0, stall}, 32'd1);
    chk_rs1 = 5'd0;
    #1 check("sb_rd0", {31'd0, stall}, 32'd0);
    chk_rs1 = 5'd4;
    set_md(5'd4, 32'h44);
    tick(); idle();
    md_start = 1'b1; md_start_rd = 5'd4;
    check_wr("sb_w4", 1'b1, 5'd4, 32'h44);
    #1 check("sb_stall_wr", {31'd0, stall}, 32'd1);
    tick(); idle();
    check("sb_set_wins", {31'd0, stall}, 32'd1);
    set_md(5'd4, 32'h45);
    tick(); idle();
    check("sb_stall_wr2", {31'd0, stall}, 32'd1);
    tick();
    check("sb_clear", {31'd0, stall}, 32'd0);

    // Mid-operation reset with a full buffer and busy[4] set.
    md_start = 1'b1; md_start_rd = 5'd4;
    set_alu(5'd13, 32'h313); set_md(5'd25, 32'h525);
    tick();
    md_start = 1'b0;
    set_alu(5'd14, 32'h314); set_md(5'd26, 32'h526);
    tick(); idle();
    check("rr_count2", {30'd0, md_count}, 32'd2);
    check("rr_stall", {31'd0, stall}, 32'd1);
    check_wr("rr_pre", 1'b1, 5'd14, 32'h314);
    #1 ctrl_reset = 1'b1;
    #1;
    check_wr("rr_async", 1'b0, 5'd0, 32'd0);
    check("rr_async_count", {30'd0, md_count}, 32'd0);
    check("rr_async_ready", {31'd0, md_ready}, 32'd1);
    check("rr_async_stall", {31'd0, stall},    32'd0);
    repeat (2) tick();
    ctrl_reset = 1'b0;
    repeat (3) tick();
    check_wr("rr_after", 1'b0, 5'd0, 32'd0);
    check("rr_after_count", {30'd0, md_count}, 32'd0);
    check("rr_after_stall", {31'd0, stall},    32'd0);
    chk_rs1 = 5'd0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
